// File: rtl/alu_share_arbiter.sv
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Round-robin sharing of one combinational ALU among NREQ
//             requesters, with registered operands and a valid/ready response.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    input  logic [NREQ*4-1:0]    req_ctl,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [3:0]           alu_ctl,
    input  logic [XLEN-1:0]      alu_result,
    input  logic                 alu_zero,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [XLEN-1:0]      resp_result,
    output logic                 resp_zero,
    output logic                 busy
);

    localparam int              PW          = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]      C_CTL_ADD   = 4'b0010;
    localparam logic [PW-1:0]   C_PTR_RESET = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_owner;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [3:0]         r_ctl;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;

    logic [PW-1:0]      w_idx;
    logic [PW-1:0]      w_winner;
    logic               w_found;
    logic [XLEN-1:0]    w_sel_a;
    logic [XLEN-1:0]    w_sel_b;
    logic [3:0]         w_sel_ctl;
    logic               w_accept;
    logic               w_resp_fire;

    // Scan from farthest to nearest so the nearest valid requester after
    // ptr is the one left in w_winner.
    always_comb begin
        w_idx    = '0;
        w_found  = 1'b0;
        w_winner = r_ptr;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_ctl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == PW'(i)) begin
                w_sel_a   = req_a[i*XLEN +: XLEN];
                w_sel_b   = req_b[i*XLEN +: XLEN];
                w_sel_ctl = req_ctl[i*4 +: 4];
            end
        end
    end

    assign w_accept    = (r_state == S_IDLE) && w_found;
    assign w_resp_fire = (r_state == S_RESP) && resp_ready[r_owner];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        resp_valid = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready = NREQ'(1) << w_winner;
                    w_next    = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = NREQ'(1) << r_owner;
                if (resp_ready[r_owner]) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ptr moves only on response completion, so a grant alone never
    // changes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= C_PTR_RESET;
            r_owner  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ctl    <= C_CTL_ADD;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_winner;
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_ctl   <= w_sel_ctl;
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
            end
            if (w_resp_fire) begin
                r_ptr <= r_owner;
            end
        end
    end

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_ctl     = r_ctl;
    assign resp_result = r_result;
    assign resp_zero   = r_zero;
    assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Self-checking bench for alu_share_arbiter (NREQ=2, XLEN=32).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 32;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_a;
    logic [NREQ*XLEN-1:0] req_b;
    logic [NREQ*4-1:0]    req_ctl;
    logic [XLEN-1:0]      alu_a;
    logic [XLEN-1:0]      alu_b;
    logic [3:0]           alu_ctl;
    logic [XLEN-1:0]      alu_result;
    logic                 alu_zero;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [XLEN-1:0]      resp_result;
    logic                 resp_zero;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU; unassigned codes return a marker value.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_ctl);
    assign alu_zero   = (alu_result == '0);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
        req_a[i*XLEN +: XLEN] = a;
        req_b[i*XLEN +: XLEN] = b;
        req_ctl[i*4 +: 4]     = c;
    endtask

    // Single isolated transaction starting in IDLE with resp_ready high.
    task automatic do_single(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] c, input logic [31:0] er, input logic ez);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << i;
        set_req(i, a, b, c);
        req_valid  = oh;
        resp_ready = '1;
        #1;
        chk("accept_req_ready", 64'(req_ready), 64'(oh));
        step();
        req_valid = '0;
        #1;
        chk("exec_busy", 64'(busy), 64'd1);
        chk("exec_alu_ctl", 64'(alu_ctl), 64'(c));
        chk("exec_alu_a", 64'(alu_a), 64'(a));
        chk("exec_alu_b", 64'(alu_b), 64'(b));
        chk("exec_resp_valid", 64'(resp_valid), 64'd0);
        step();
        chk("resp_valid", 64'(resp_valid), 64'(oh));
        chk("resp_result", 64'(resp_result), 64'(er));
        chk("resp_zero", 64'(resp_zero), 64'(ez));
        step();
        chk("back_idle_busy", 64'(busy), 64'd0);
        chk("back_idle_resp_valid", 64'(resp_valid), 64'd0);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[8];

    // Transaction-level reference for the random phase.
    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        int g;
        int waited;
        logic [NREQ-1:0] rv;
        int m_phase, m_last, m_owner, acc;
        logic [31:0] m_a, m_b, m_res;
        logic [3:0]  m_ctl;
        logic        m_zero;

        vecs[0] = '{0, 32'd5,          32'd7,  4'b0010, 32'd12,         1'b0};
        vecs[1] = '{1, 32'd9,          32'd9,  4'b0110, 32'd0,          1'b1};
        vecs[2] = '{0, 32'hF0,         32'h3C, 4'b0000, 32'h30,         1'b0};
        vecs[3] = '{1, 32'hF0,         32'h0F, 4'b0001, 32'hFF,         1'b0};
        vecs[4] = '{0, 32'hFFFF_FFFF,  32'd1,  4'b0111, 32'd1,          1'b0};
        vecs[5] = '{1, 32'd0,          32'd0,  4'b1100, 32'hFFFF_FFFF,  1'b0};
        vecs[6] = '{0, 32'd1,          32'd2,  4'b1111, 32'hDEAD_BEEF,  1'b0};
        vecs[7] = '{1, 32'hFFFF_FFFF,  32'd1,  4'b0010, 32'd0,          1'b1};

        reset = 1'b1; req_valid = '0; resp_ready = '0;
        req_a = '0; req_b = '0; req_ctl = '0;
        do_reset();

        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_alu_ctl", 64'(alu_ctl), 64'b0010);
        chk("reset_alu_a", 64'(alu_a), 64'd0);
        chk("reset_alu_b", 64'(alu_b), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_result", 64'(resp_result), 64'd0);
        chk("reset_resp_zero", 64'(resp_zero), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);

        foreach (vecs[v]) begin
            do_single(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].ctl,
                      vecs[v].exp_res, vecs[v].exp_zero);
        end

        // Both requesters valid: strict alternation starting at 0.
        do_reset();
        set_req(0, 32'd0, 32'd1, 4'b0010);
        set_req(1, 32'd1, 32'd1, 4'b0010);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int n = 0; n < 4; n++) begin
            waited = 0;
            #1;
            while (req_ready == '0 && waited < 10) begin
                step();
                waited++;
            end
            chk("rr_grant_immediate", 64'(waited), 64'd0);
            g = (req_ready == 2'b10) ? 1 : 0;
            chk("rr_grant_order", 64'(req_ready), 64'(NREQ'(1) << (n % 2)));
            step();
            step();
            chk("rr_resp_valid", 64'(resp_valid), 64'(NREQ'(1) << g));
            chk("rr_result", 64'(resp_result), 64'(g + 1));
            step();
        end

        // Backpressure on requester 0 while 1 waits and 0 re-requests.
        do_reset();
        set_req(0, 32'd5, 32'd7, 4'b0010);
        set_req(1, 32'd3, 32'd4, 4'b0010);
        req_valid  = 2'b11;
        resp_ready = 2'b00;
        #1;
        chk("bp_grant0", 64'(req_ready), 64'b01);
        step();
        step();
        for (int n = 0; n < 4; n++) begin
            chk("bp_resp_valid", 64'(resp_valid), 64'b01);
            chk("bp_result", 64'(resp_result), 64'd12);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        resp_ready = 2'b10;
        #1;
        chk("bp_ignore_nonowner", 64'(resp_valid), 64'b01);
        step();
        chk("bp_still_resp", 64'(resp_valid), 64'b01);
        resp_ready = 2'b01;
        step();
        chk("bp_grant1_after", 64'(req_ready), 64'b10);
        step();
        req_valid = '0;
        step();
        chk("bp_r1_result", 64'(resp_result), 64'd7);
        resp_ready = 2'b11;
        step();

        // Reset during EXEC discards the operation.
        do_reset();
        set_req(0, 32'd1, 32'd2, 4'b0110);
        req_valid  = 2'b01;
        resp_ready = 2'b11;
        step();
        req_valid = '0;
        chk("rx_in_exec", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rx_busy", 64'(busy), 64'd0);
        chk("rx_alu_ctl", 64'(alu_ctl), 64'b0010);
        chk("rx_alu_a", 64'(alu_a), 64'd0);
        chk("rx_resp_valid", 64'(resp_valid), 64'd0);
        step();
        chk("rx_no_resp", 64'(resp_valid), 64'd0);
        do_single(0, 32'hF0, 32'h3C, 4'b0000, 32'h30, 1'b0);

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_phase = 0; m_last = NREQ - 1; m_owner = 0; acc = -1;
        m_a = '0; m_b = '0; m_ctl = 4'b0010; m_res = '0; m_zero = 1'b0;
        rv = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc == i || !rv[i]) begin
                    rv[i] = (acc == i) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1));
                    if (rv[i]) begin
                        logic [31:0] ra;
                        ra = $urandom;
                        set_req(i, ra, ($urandom_range(0, 3) == 0) ? ra : 32'($urandom),
                                4'($urandom_range(0, 15)));
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            req_valid  = rv;
            resp_ready = NREQ'($urandom);
            #1;
            g = pick(req_valid, m_last);
            if (m_phase == 0) begin
                chk("rnd_req_ready", 64'(req_ready), (g < 0) ? 64'd0 : 64'(NREQ'(1) << g));
                chk("rnd_busy", 64'(busy), 64'd0);
                chk("rnd_resp_valid", 64'(resp_valid), 64'd0);
            end else if (m_phase == 1) begin
                chk("rnd_exec_ready", 64'(req_ready), 64'd0);
                chk("rnd_exec_ctl", 64'(alu_ctl), 64'(m_ctl));
                chk("rnd_exec_a", 64'(alu_a), 64'(m_a));
                chk("rnd_exec_b", 64'(alu_b), 64'(m_b));
                chk("rnd_busy", 64'(busy), 64'd1);
            end else begin
                chk("rnd_resp_ready", 64'(req_ready), 64'd0);
                chk("rnd_resp_valid", 64'(resp_valid), 64'(NREQ'(1) << m_owner));
                chk("rnd_result", 64'(resp_result), 64'(m_res));
                chk("rnd_zero", 64'(resp_zero), 64'(m_zero));
            end
            @(posedge clk);
            acc = -1;
            if (m_phase == 0) begin
                if (g >= 0) begin
                    acc     = g;
                    m_owner = g;
                    m_a     = req_a[g*XLEN +: XLEN];
                    m_b     = req_b[g*XLEN +: XLEN];
                    m_ctl   = req_ctl[g*4 +: 4];
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_res   = alu_ref(m_a, m_b, m_ctl);
                m_zero  = (m_res == '0);
                m_phase = 2;
            end else if (resp_ready[m_owner]) begin
                m_last  = m_owner;
                m_phase = 0;
            end
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU and its 4-bit ALU-control encoding among NREQ requesters, e.g. the main execute path, an address-generation helper and a debug/test port.
- Arbitrates round-robin, registers the winner's operands and control code, drives the shared ALU for one cycle, and captures the result and zero flag.
- Returns the result to the winning requester over a valid/ready response handshake.
- Sits between the requesters and the ALU.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- XLEN, 32, operand and result width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; combinational.
- req_a  input  NREQ*XLEN  packed operand A; requester i uses bits [i*XLEN +: XLEN].
- req_b  input  NREQ*XLEN  packed operand B, same packing as req_a.
- req_ctl  input  NREQ*4  packed 4-bit ALU control code; requester i uses bits [i*4 +: 4].
- alu_a  output  XLEN  operand A to the shared ALU.
- alu_b  output  XLEN  operand B to the shared ALU.
- alu_ctl  output  4  control code to the shared ALU.
- alu_result  input  XLEN  shared ALU result; combinational from alu_a, alu_b, alu_ctl.
- alu_zero  input  1  shared ALU zero flag.
- resp_valid  output  NREQ  one-hot response valid, asserted to the owner only.
- resp_ready  input  NREQ  per-requester response accept.
- resp_result  output  XLEN  captured result, common to all requesters.
- resp_zero  output  1  captured zero flag.
- busy  output  1  high when state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - state = IDLE; ptr (last granted index) = NREQ-1, so requester 0 has first priority.
  - Operand registers = 0; control register = 4'b0010 (add).
  - alu_a = 0, alu_b = 0, alu_ctl = 4'b0010.
  - resp_valid = 0, resp_result = 0, resp_zero = 0, busy = 0.
- Outputs alu_a, alu_b and alu_ctl are always driven from the operand/control registers, never directly from req_*.
- IDLE:
  - Winner = first i with req_valid[i] = 1, scanning ptr+1, ptr+2, ... modulo NREQ.
  - req_ready[winner] = 1; every other req_ready bit = 0.
  - If any request is valid: on the edge, latch the winner's A, B and ctl, set owner = winner, go to EXEC.
  - If no request is valid: req_ready = 0 and the state holds.
- EXEC:
  - req_ready = 0. The ALU sees the latched operands for exactly one cycle.
  - On the edge, capture alu_result into resp_result and alu_zero into resp_zero, then go to RESP.
- RESP:
  - resp_valid[owner] = 1; resp_result and resp_zero are held stable.
  - When resp_ready[owner] = 1, on the edge: ptr = owner, resp_valid cleared, go to IDLE.
  - resp_ready bits of non-owners are ignored.
- Latency and throughput:
  - Request accepted at edge N; result captured at edge N+1; resp_valid high from cycle N+1 until the handshake.
  - Minimum of 3 cycles per operation, measured from IDLE back to IDLE.
- Boundary conditions:
  - Requesters that are not granted must hold req_valid and their data; dropping req_valid before grant is legal and simply removes them from arbitration.
  - All NREQ requesters valid: grants rotate strictly in the order 0,1,...,NREQ-1,0,...
  - A single persistent requester is granted every operation.
  - The owner may present a new request while its response is pending; it is not accepted until IDLE.
  - No transaction combines response and accept: acceptance only happens in the cycle after the response handshake.
  - Reset asserted in any state: the in-flight operation is discarded, with no response, and all reset values apply on the next edge.
  - ALU control codes pass through unmodified, including unassigned codes; the ALU's default handling applies to them.
  - ptr is updated only on response completion, not on grant.

Test Plan:
- Requester 0 only: A=5, B=7, ctl=0010, resp_ready held high. Expected: req_ready[0] high in the accept cycle; resp_valid = 01 two cycles later with result = 12, zero = 0; back in IDLE the following cycle.
- Requester 1 only: A=9, B=9, ctl=0110. Expected: resp_valid = 10, result = 0, zero = 1.
- Both requesters valid every cycle, NREQ=2, A=i, B=1, ctl=0010. Expected: grant order 0,1,0,1; results 1,2,1,2; no back-to-back repeat while the other is valid.
- Backpressure: hold resp_ready[0] low for 4 cycles while requester 1 is valid. Expected: resp_valid[0] and result stay stable and req_ready stays 0; after the resp_ready handshake, requester 1 is granted in IDLE.
- Reset in EXEC, then requester 0 with ctl=0000, A=0xF0, B=0x3C. Expected: no response for the aborted operation; after reset, alu_ctl = 0010 and busy = 0; the new operation returns result 0x30.
- Requester 0 with ctl=1111, A=1, B=2. Expected: alu_ctl = 1111 during EXEC, and the response carries whatever alu_result the ALU drives.
